// File: rtl/apb_slave_mem.sv
// APB completer memory: word-addressed RAM with programmable wait states,
// registered PREADY pulse and an out-of-range / conflicting-strobe error flag.
module apb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  dir_q, dir_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  mem_we;
    logic                  out_of_range;
    logic                  unused_penable;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // PENABLE is observed only; the transfer is driven by PSEL and the strobes.
    assign unused_penable = PENABLE;
    assign out_of_range   = 32'(PADDR) >= 32'(MEM_DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dir_d     = dir_q;
        rd_d      = rd_q;
        err_d     = err_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            StIdle: begin
                if (PSEL && (read || write)) begin
                    addr_d  = PADDR[IDX_W-1:0];
                    wdata_d = PWDATA;
                    dir_d   = write;
                    rd_d    = read;
                    err_d   = (read && write) || out_of_range;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d   = StResp;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    // Erroring reads (including read+write) return zero; erroring writes drop.
                    if (err_q) begin
                        if (rd_q) begin
                            prdata_d = '0;
                        end
                    end else if (dir_q) begin
                        mem_we = 1'b1;
                    end else begin
                        prdata_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StHold;
            end
            StHold: begin
                if (!PSEL || !(read || write)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dir_q     <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dir_q     <= dir_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with 2 wait states, one with 0,
// sharing the bus signals but with independent resets.
module tb_apb_slave_mem;

    logic        PCLK;
    logic        rst2_n;
    logic        rst0_n;
    logic        PSEL;
    logic        PENABLE;
    logic        read;
    logic        write;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] prdata2, prdata0;
    logic        pready2, pready0;
    logic        pslverr2, pslverr0;

    int checks = 0;
    int errors = 0;

    apb_slave_mem #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (256),
        .WAIT_STATES(2)
    ) dut2 (
        .PCLK   (PCLK),
        .PRESETn(rst2_n),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .read   (read),
        .write  (write),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (prdata2),
        .PREADY (pready2),
        .PSLVERR(pslverr2)
    );

    apb_slave_mem #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (256),
        .WAIT_STATES(0)
    ) dut0 (
        .PCLK   (PCLK),
        .PRESETn(rst0_n),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .read   (read),
        .write  (write),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (prdata0),
        .PREADY (pready0),
        .PSLVERR(pslverr0)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transfer; called at a negedge with the bus idle. Strobes are held for
    // 'hold' cycles after PREADY to mimic the bridge clearing them late.
    task automatic xfer(input bit use0, input logic rd, input logic wr, input logic [9:0] addr,
                        input logic [31:0] data, input logic exp_err,
                        input logic [31:0] exp_rdata, input int hold);
        int   n;
        logic seen;
        int   exp_lat;
        exp_lat = use0 ? 1 : 3;
        PSEL    = 1'b1;
        read    = rd;
        write   = wr;
        PADDR   = addr;
        PWDATA  = data;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge PCLK);
            n++;
            @(negedge PCLK);
            seen = use0 ? pready0 : pready2;
        end
        check("latency", n, exp_lat);
        check("pslverr", use0 ? pslverr0 : pslverr2, exp_err);
        check("prdata", use0 ? prdata0 : prdata2, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            check("pready_once", use0 ? pready0 : pready2, 0);
        end
        PSEL    = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("prdata_hold", use0 ? prdata0 : prdata2, exp_rdata);
        check("pslverr_idle", use0 ? pslverr0 : pslverr2, 0);
    endtask

    initial begin
        rst2_n  = 1'b1;
        rst0_n  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        #1;
        rst2_n = 1'b0;
        rst0_n = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("rst_prdata", prdata2, 0);
            check("rst_pready", pready2, 0);
            check("rst_pslverr", pslverr2, 0);
            check("rst_pready0", pready0, 0);
        end
        rst2_n = 1'b1;
        rst0_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("idle_pready", pready2, 0);
            check("idle_prdata", prdata2, 0);
        end

        // Write/read and range checks, 2 wait states
        xfer(0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1);
        xfer(0, 1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 32'hDEADBEEF, 1);
        xfer(0, 1'b0, 1'b1, 10'h000, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 1);
        xfer(0, 1'b0, 1'b1, 10'h0FF, 32'h0F0F0F0F, 1'b0, 32'hDEADBEEF, 1);
        xfer(0, 1'b1, 1'b0, 10'h0FF, 32'h0,        1'b0, 32'h0F0F0F0F, 1);
        xfer(0, 1'b0, 1'b1, 10'h100, 32'h12345678, 1'b1, 32'h0F0F0F0F, 1);
        xfer(0, 1'b1, 1'b0, 10'h100, 32'h0,        1'b1, 32'h0000_0000, 1);
        xfer(0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 32'hCAFEF00D, 1);
        xfer(0, 1'b1, 1'b1, 10'h005, 32'h0,        1'b1, 32'h0000_0000, 1);
        xfer(0, 1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 32'hDEADBEEF, 1);
        xfer(0, 1'b1, 1'b0, 10'h3FF, 32'h0,        1'b1, 32'h0000_0000, 1);
        xfer(0, 1'b0, 1'b1, 10'h010, 32'hA5A50010, 1'b0, 32'h0000_0000, 1);

        // Abort: PSEL dropped while waiting
        PSEL   = 1'b1;
        write  = 1'b1;
        read   = 1'b0;
        PADDR  = 10'h010;
        PWDATA = 32'hFFFF_FFFF;
        @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_wait", pready2, 0);
        PSEL  = 1'b0;
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            check("abort_no_ready", pready2, 0);
        end

        // Read back after abort with strobes held long: must not re-trigger
        xfer(0, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0, 32'hA5A50010, 6);

        // Zero wait states instance, after a fresh reset
        rst0_n = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("rst0_prdata", prdata0, 0);
        rst0_n = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        xfer(1, 1'b0, 1'b1, 10'h020, 32'h11112222, 1'b0, 32'h0000_0000, 1);
        xfer(1, 1'b1, 1'b0, 10'h020, 32'h0,        1'b0, 32'h11112222, 1);

        // Async reset while waiting: no PREADY, no commit
        PSEL   = 1'b1;
        write  = 1'b1;
        read   = 1'b0;
        PADDR  = 10'h020;
        PWDATA = 32'hBAD0BAD0;
        @(posedge PCLK);
        @(negedge PCLK);
        rst0_n = 1'b0;
        #1;
        check("midrst_pready", pready0, 0);
        check("midrst_prdata", prdata0, 0);
        check("midrst_pslverr", pslverr0, 0);
        PSEL  = 1'b0;
        write = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("midrst_hold_pready", pready0, 0);
        rst0_n = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        xfer(1, 1'b1, 1'b0, 10'h020, 32'h0, 1'b0, 32'h11112222, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
